// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM state encoding
// and the 3-sample majority vote.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Word output channel of the UART receiver: data plus per-word flags,
// valid/ready handshake and the overrun pulse.
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data, valid, parity_err, frame_err, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, parity_err, frame_err, overrun,
        output ready
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, per-bit counter and mid-bit majority sampler. Emits one
// bit_strobe/bit_val pair per bit period and bit_end on the last count.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             start,
    output logic             rs,
    output logic             bit_strobe,
    output logic             bit_val,
    output logic             bit_end
);

    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic [DIV_W-1:0]       div;
    logic [DIV_W-1:0]       cnt;
    logic [DIV_W-1:0]       half;
    logic                   samp_a;
    logic                   samp_b;

    assign rs   = sync[SYNC_STAGES-1];
    assign half = div >> 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
        end
    end

    // The divisor is captured only at start detect so mid-frame edits are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= MIN_DIV;
            cnt    <= '0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (start) begin
                div <= (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
                cnt <= '0;
            end else if (bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
            if (cnt == half - ONE) samp_a <= rs;
            if (cnt == half)       samp_b <= rs;
        end
    end

    // Third sample is the live rs value, so the vote resolves at cnt = h+1.
    assign bit_strobe = (cnt == half + ONE);
    assign bit_val    = maj3(samp_a, samp_b, rs);
    assign bit_end    = (cnt == div - ONE);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM on top of the majority sampler, with a
// one-entry valid/ready output buffer and overrun reporting.
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    output logic             busy,
    uart_rx_cfg_if.master    word
);

    import uart_pkg::*;

    localparam bit         HAS_PAR  = (PARITY != PAR_NONE);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               state;
    logic                 armed;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_f;
    logic                 frm_f;
    logic                 rs;
    logic                 bit_strobe;
    logic                 bit_val;
    logic                 bit_end;
    logic                 start;
    logic                 final_stop;
    logic                 frame_now;

    function automatic logic par_expect(input logic [DATA_BITS-1:0] d);
        case (PARITY)
            PAR_ODD:  return ~^d;
            PAR_EVEN: return ^d;
            default:  return 1'b0;
        endcase
    endfunction

    uart_rx_sampler #(
        .DIV_W      (DIV_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) sampler (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .baud_div  (baud_div),
        .start     (start),
        .rs        (rs),
        .bit_strobe(bit_strobe),
        .bit_val   (bit_val),
        .bit_end   (bit_end)
    );

    // armed blocks a held-low line (break) from re-triggering a frame.
    assign start      = (state == IDLE) && armed && !rs;
    assign final_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign frame_now  = frm_f | ~bit_val;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            armed           <= 1'b0;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            shreg           <= '0;
            par_f           <= 1'b0;
            frm_f           <= 1'b0;
            word.data       <= '0;
            word.valid      <= 1'b0;
            word.parity_err <= 1'b0;
            word.frame_err  <= 1'b0;
            word.overrun    <= 1'b0;
        end else begin
            word.overrun <= 1'b0;
            if (word.valid && word.ready) word.valid <= 1'b0;
            if (state == IDLE && rs) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= START;
                        armed    <= 1'b0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        par_f    <= 1'b0;
                        frm_f    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_strobe && bit_val) state <= IDLE;
                    else if (bit_end)          state <= DATA;
                end
                DATA: begin
                    if (bit_strobe) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= HAS_PAR ? uart_pkg::PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (bit_strobe) par_f <= (bit_val != par_expect(shreg));
                    if (bit_end)    state <= STOP;
                end
                STOP: begin
                    if (bit_strobe) begin
                        frm_f <= frame_now;
                        // Leave at the final sample so a start half a bit later is caught.
                        if (final_stop) begin
                            state <= IDLE;
                            if (!word.valid || word.ready) begin
                                word.data       <= shreg;
                                word.parity_err <= par_f;
                                word.frame_err  <= frame_now;
                                word.valid      <= 1'b1;
                            end else begin
                                word.overrun <= 1'b1;
                            end
                        end
                    end
                    if (bit_end && !final_stop) stop_idx <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
